// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - request/result bundle between the control unit and the iterative divider
interface iter_divider_if #(
  parameter int X = 32
) ();
  logic         start;
  logic         signed_op;
  logic [X-1:0] a;
  logic [X-1:0] b;
  logic         busy;
  logic         done;
  logic [X-1:0] quotient;
  logic [X-1:0] remainder;
  logic         div_zero;

  // Control unit side: issues operands, watches busy/done and collects LO/HI.
  modport master (
    output start, signed_op, a, b,
    input  busy, done, quotient, remainder, div_zero
  );

  // Divider side.
  modport slave (
    input  start, signed_op, a, b,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle restoring divider for DIV/DIVU; signed support under DIV_SIGNED_EN
module iter_divider #(
  parameter int X = 32
) (
  input  logic         clk,
  input  logic         rst,
  iter_divider_if.slave bus
);

  localparam int CW = $clog2(X + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t         state;
  logic [X-1:0]   rem;
  logic [X-1:0]   dvd;
  logic [X-1:0]   divisor;
  logic [X-1:0]   a_orig;
  logic [CW-1:0]  cnt;
  logic           dz;
  logic           neg_q;
  logic           neg_r;

  logic [X-1:0]   mag_a;
  logic [X-1:0]   mag_b;
  logic           neg_q_in;
  logic           neg_r_in;
  logic [X:0]     shifted;
  logic [X:0]     trial;

`ifdef DIV_SIGNED_EN
  logic sign_a;
  logic sign_b;

  // Operand magnitudes; the most-negative value maps onto 2^(X-1) unsigned, which is what we want.
  assign sign_a   = bus.signed_op & bus.a[X-1];
  assign sign_b   = bus.signed_op & bus.b[X-1];
  assign mag_a    = sign_a ? -bus.a : bus.a;
  assign mag_b    = sign_b ? -bus.b : bus.b;
  assign neg_q_in = sign_a ^ sign_b;
  assign neg_r_in = sign_a;
`else
  logic unused_signed_op;

  // Unsigned-only build: operands pass straight through and no sign fix-up exists.
  assign unused_signed_op = bus.signed_op;
  assign mag_a    = bus.a;
  assign mag_b    = bus.b;
  assign neg_q_in = 1'b0;
  assign neg_r_in = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  // The partial remainder is always below the divisor, so X+1 bits hold the trial without overflow.
  assign shifted = {rem, dvd[X-1]};
  assign trial   = shifted - {1'b0, divisor};

  // Control FSM and datapath; dvd is shifted out MSB-first while quotient bits shift in at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rem           <= '0;
      dvd           <= '0;
      divisor       <= '0;
      a_orig        <= '0;
      cnt           <= '0;
      dz            <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.busy <= bus.start;
          if (bus.start) begin
            dvd     <= mag_a;
            divisor <= mag_b;
            a_orig  <= bus.a;
            neg_q   <= neg_q_in;
            neg_r   <= neg_r_in;
            dz      <= (bus.b == '0);
            rem     <= '0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (trial[X]) begin
            rem <= shifted[X-1:0];
            dvd <= {dvd[X-2:0], 1'b0};
          end else begin
            rem <= trial[X-1:0];
            dvd <= {dvd[X-2:0], 1'b1};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(X - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Divide-by-zero returns the MIPS-style all-ones quotient and the untouched dividend.
          if (dz) begin
            bus.quotient  <= '1;
            bus.remainder <= a_orig;
          end else begin
            bus.quotient  <= neg_q ? -dvd : dvd;
            bus.remainder <= neg_r ? -rem : rem;
          end
          bus.div_zero <= dz;
          state        <= DONE;
        end
        DONE: begin
          // busy stays high through the done cycle; IDLE drops it unless a new start arrives.
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - scoreboard bench for iter_divider: directed vectors, latency and reset behaviour
module tb_iter_divider;

  localparam int X = 32;

  typedef struct {
    logic [X-1:0] q;
    logic [X-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sbq[$];

  iter_divider_if #(.X(X)) bus ();

  iter_divider #(.X(X)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to check start-to-done latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [X-1:0] act, input logic [X-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("quotient", bus.quotient, e.q);
        chk("remainder", bus.remainder, e.r);
        chk("div_zero", X'(bus.div_zero), X'(e.dz));
        chk("done_cycle", X'(cyc), X'(e.cyc));
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic sop, input logic [X-1:0] a, input logic [X-1:0] b,
                       input logic push, input logic [X-1:0] eq, input logic [X-1:0] er,
                       input logic edz);
    exp_t e;
    bus.start     = 1'b1;
    bus.signed_op = sop;
    bus.a         = a;
    bus.b         = b;
    if (push) begin
      e.q   = eq;
      e.r   = er;
      e.dz  = edz;
      e.cyc = cyc + X + 3;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_start", X'(bus.busy), X'(1));
  endtask

  // Returns at the negedge on which done is seen.
  task automatic wait_done();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
  endtask

  task automatic run_op(input logic sop, input logic [X-1:0] a, input logic [X-1:0] b,
                        input logic [X-1:0] eq, input logic [X-1:0] er, input logic edz);
    issue(sop, a, b, 1'b1, eq, er, edz);
    wait_done();
    @(negedge clk);
    chk("busy_after_done", X'(bus.busy), X'(0));
    chk("done_single", X'(bus.done), X'(0));
  endtask

  initial begin
    int ndone;
    cyc           = 0;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", X'(bus.busy), X'(0));
    chk("rst_done", X'(bus.done), X'(0));
    chk("rst_quotient", bus.quotient, X'(0));
    chk("rst_remainder", bus.remainder, X'(0));
    chk("rst_div_zero", X'(bus.div_zero), X'(0));
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
`ifdef DIV_SIGNED_EN
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
`else
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd7, 1'b0);
`endif
    run_op(1'b1, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1);
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);

    // Start while busy is ignored; a start right after done is accepted back-to-back.
    issue(1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0);
    repeat (8) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    issue(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0);
    wait_done();
    @(negedge clk);
    chk("busy_after_b2b", X'(bus.busy), X'(0));

    run_op(1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0);

    // Reset in the middle of an operation abandons it and clears the results.
    issue(1'b0, 32'd1000, 32'd3, 1'b0, '0, '0, 1'b0);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", X'(bus.busy), X'(0));
    chk("midrst_done", X'(bus.done), X'(0));
    chk("midrst_quotient", bus.quotient, X'(0));
    chk("midrst_remainder", bus.remainder, X'(0));
    chk("midrst_div_zero", X'(bus.div_zero), X'(0));
    rst   = 1'b0;
    ndone = 0;
    repeat (45) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("no_done_after_rst", X'(ndone), X'(0));
    chk("scoreboard_empty", X'(sbq.size()), X'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
